// File: rtl/dac_share_pkg.sv
// Shared definitions for the DAC/ADC sharing arbiters.
// Holds the state encoding and the default DAC word width.
package dac_share_pkg;

    localparam int DAC_WID_DEF = 24;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] XFER    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = IDLE,
        S_XFER    = XFER,
        S_RELEASE = RELEASE
    } state_t;

endpackage

// File: rtl/dac_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Ports: req (request vector), ptr (search start) -> valid, idx.
module rr_pick #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    int best_d;
    int d;

    // Pick the set bit with the smallest distance above ptr, modulo N.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        best_d = N;
        d      = 0;
        for (int j = 0; j < N; j++) begin
            d = j - int'(ptr);
            if (d < 0) d = d + N;
            if (req[j] && d < best_d) begin
                best_d = d;
                idx    = W'(j);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_share_arbiter.sv
// Round-robin arbiter sharing one DAC SPI master among NUM_REQ requesters.
// Ports: clk, rst (async high); per-requester req_arm/req_finished/req_out/req_in
// (packed, word i at [i*DAC_WID +: DAC_WID]); dac_arm/dac_finished/dac_out/dac_in
// to the DAC master; busy, grant_id, timeout_err status.
// Optional: DAC_SHARE_ARBITER_TIMEOUT_EN adds timeout_cycles and a watchdog.
module dac_share_arbiter
    import dac_share_pkg::*;
#(
    parameter int DAC_WID     = DAC_WID_DEF,
    parameter int NUM_REQ     = 3,
    parameter int REQ_IDX_WID = 2,
    parameter int TIMEOUT_WID = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_arm,
    output logic [NUM_REQ-1:0]         req_finished,
    input  logic [NUM_REQ*DAC_WID-1:0] req_out,
    output logic [NUM_REQ*DAC_WID-1:0] req_in,
    output logic                       dac_arm,
    input  logic                       dac_finished,
    output logic [DAC_WID-1:0]         dac_out,
    input  logic [DAC_WID-1:0]         dac_in,
`ifdef DAC_SHARE_ARBITER_TIMEOUT_EN
    input  logic [TIMEOUT_WID-1:0]     timeout_cycles,
`endif
    output logic                       busy,
    output logic [REQ_IDX_WID-1:0]     grant_id,
    output logic                       timeout_err
);

    if ((2 ** REQ_IDX_WID) < NUM_REQ || NUM_REQ < 2 || TIMEOUT_WID < 1) begin : g_bad_cfg
        $error("dac_share_arbiter: bad parameters");
    end

    state_t                 state;
    logic [REQ_IDX_WID-1:0] rr_ptr;
    logic                   aborted;
    logic                   pick_valid;
    logic [REQ_IDX_WID-1:0] pick_idx;
    logic [DAC_WID-1:0]     pick_word;
    logic                   arm_g;
    logic [REQ_IDX_WID-1:0] g_next;

    rr_pick #(
        .N (NUM_REQ),
        .W (REQ_IDX_WID)
    ) u_pick (
        .req   (req_arm),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        arm_g     = 1'b0;
        pick_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == REQ_IDX_WID'(i)) arm_g = req_arm[i];
            if (pick_idx == REQ_IDX_WID'(i)) pick_word = req_out[i*DAC_WID +: DAC_WID];
        end
    end

    // Wrap at NUM_REQ, not at the index width.
    assign g_next = (grant_id == REQ_IDX_WID'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy   = (state != S_IDLE);

`ifdef DAC_SHARE_ARBITER_TIMEOUT_EN
    logic [TIMEOUT_WID-1:0] tmr;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            dac_arm      <= 1'b0;
            dac_out      <= '0;
            req_finished <= '0;
            req_in       <= '0;
            aborted      <= 1'b0;
`ifdef DAC_SHARE_ARBITER_TIMEOUT_EN
            tmr          <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        dac_out  <= pick_word;
                        dac_arm  <= 1'b1;
                        aborted  <= 1'b0;
                        state    <= S_XFER;
`ifdef DAC_SHARE_ARBITER_TIMEOUT_EN
                        tmr      <= timeout_cycles;
`endif
                    end
                end
                S_XFER: begin
                    // An aborted transfer still runs to completion on the bus.
                    if (!arm_g) aborted <= 1'b1;
                    if (dac_finished) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (grant_id == REQ_IDX_WID'(i)) begin
                                req_in[i*DAC_WID +: DAC_WID] <= dac_in;
                                req_finished[i] <= arm_g && !aborted;
                            end
                        end
                        dac_arm <= 1'b0;
                        state   <= S_RELEASE;
                    end
`ifdef DAC_SHARE_ARBITER_TIMEOUT_EN
                    // tmr==0 means the watchdog is off; it fires as it would hit 0.
                    else if (tmr == TIMEOUT_WID'(1)) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (grant_id == REQ_IDX_WID'(i))
                                req_finished[i] <= arm_g && !aborted;
                        end
                        dac_arm     <= 1'b0;
                        timeout_err <= 1'b1;
                        tmr         <= '0;
                        state       <= S_RELEASE;
                    end else if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end
`endif
                end
                S_RELEASE: begin
                    if (!arm_g && !dac_finished) begin
                        req_finished <= '0;
                        rr_ptr       <= g_next;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_share_arbiter.sv
// Directed self-checking bench for dac_share_arbiter (NUM_REQ=3, DAC_WID=24).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dac_share_arbiter;

    localparam int DW = 24;
    localparam int NR = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_arm;
    logic [NR-1:0]   req_finished;
    logic [NR*DW-1:0] req_out;
    logic [NR*DW-1:0] req_in;
    logic            dac_arm;
    logic            dac_finished;
    logic [DW-1:0]   dac_out;
    logic [DW-1:0]   dac_in;
    logic            busy;
    logic [IW-1:0]   grant_id;
    logic            timeout_err;
`ifdef DAC_SHARE_ARBITER_TIMEOUT_EN
    logic [15:0]     timeout_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dac_share_arbiter #(
        .DAC_WID     (DW),
        .NUM_REQ     (NR),
        .REQ_IDX_WID (IW),
        .TIMEOUT_WID (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_arm      (req_arm),
        .req_finished (req_finished),
        .req_out      (req_out),
        .req_in       (req_in),
        .dac_arm      (dac_arm),
        .dac_finished (dac_finished),
        .dac_out      (dac_out),
        .dac_in       (dac_in),
`ifdef DAC_SHARE_ARBITER_TIMEOUT_EN
        .timeout_cycles (timeout_cycles),
`endif
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rin(input int i);
        return req_in[i*DW +: DW];
    endfunction

    logic [DW-1:0] words [NR];
    int            order [4];

    initial begin
        rst          = 1'b1;
        req_arm      = '0;
        req_out      = '0;
        dac_finished = 1'b0;
        dac_in       = '0;
`ifdef DAC_SHARE_ARBITER_TIMEOUT_EN
        timeout_cycles = '0;
`endif
        words[0] = 24'h100001;
        words[1] = 24'h200002;
        words[2] = 24'h300003;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;

        // Reset values
        step();
        chk("rst_arm", 64'(dac_arm), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_gid", 64'(grant_id), 64'h0);
        chk("rst_fin", 64'(req_finished), 64'h0);
        chk("rst_dout", 64'(dac_out), 64'h0);
        chk("rst_rin1", 64'(rin(1)), 64'h0);
        chk("rst_terr", 64'(timeout_err), 64'h0);
        rst = 1'b0;

        // Single request from requester 1
        step();
        req_out[1*DW +: DW] = 24'h1ABCDE;
        req_arm = 3'b010;
        step();
        chk("s_arm", 64'(dac_arm), 64'h1);
        chk("s_dout", 64'(dac_out), 64'h1ABCDE);
        chk("s_gid", 64'(grant_id), 64'h1);
        chk("s_busy", 64'(busy), 64'h1);
        req_out[1*DW +: DW] = 24'h555555;
        repeat (9) step();
        chk("s_dout_stable", 64'(dac_out), 64'h1ABCDE);
        chk("s_fin_wait", 64'(req_finished), 64'h0);
        dac_finished = 1'b1;
        dac_in = 24'h012345;
        step();
        chk("s_arm_lo", 64'(dac_arm), 64'h0);
        chk("s_fin", 64'(req_finished), 64'h2);
        chk("s_rin1", 64'(rin(1)), 64'h012345);
        dac_finished = 1'b0;
        step();
        chk("s_fin_hold", 64'(req_finished), 64'h2);
        req_arm = 3'b000;
        step();
        chk("s_fin_clr", 64'(req_finished), 64'h0);
        chk("s_idle", 64'(busy), 64'h0);

        // Contention from rr_ptr=0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) req_out[i*DW +: DW] = words[i];
        req_arm = 3'b111;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("c_arm", 64'(dac_arm), 64'h1);
            chk("c_gid", 64'(grant_id), 64'(order[k]));
            chk("c_dout", 64'(dac_out), 64'(words[order[k]]));
            dac_finished = 1'b1;
            dac_in = DW'(24'h0A0000 + k);
            step();
            chk("c_fin_onehot", 64'(req_finished), 64'(3'b001 << order[k]));
            dac_finished = 1'b0;
            req_arm[order[k]] = 1'b0;
            step();
            chk("c_fin_clr", 64'(req_finished), 64'h0);
            chk("c_gap", 64'(busy), 64'h0);
            if (k < 3) req_arm[order[k]] = 1'b1;
            else req_arm = 3'b000;
            step();
        end
        chk("c_end_idle", 64'(busy), 64'h0);

        // Abort by requester 2 (rr_ptr=1)
        req_arm = 3'b100;
        step();
        chk("a_arm", 64'(dac_arm), 64'h1);
        chk("a_gid", 64'(grant_id), 64'h2);
        repeat (3) step();
        req_arm = 3'b000;
        repeat (3) step();
        chk("a_arm_held", 64'(dac_arm), 64'h1);
        chk("a_fin0", 64'(req_finished), 64'h0);
        dac_finished = 1'b1;
        dac_in = 24'h0ABCDE;
        step();
        chk("a_arm_lo", 64'(dac_arm), 64'h0);
        chk("a_fin_none", 64'(req_finished), 64'h0);
        chk("a_rin2", 64'(rin(2)), 64'h0ABCDE);
        chk("a_release", 64'(busy), 64'h1);
        dac_finished = 1'b0;
        step();
        chk("a_idle", 64'(busy), 64'h0);
        req_out[0] = 1'b0;
        req_out[0*DW +: DW] = 24'h777777;
        req_arm = 3'b001;
        step();
        chk("a_next_gid", 64'(grant_id), 64'h0);
        chk("a_next_dout", 64'(dac_out), 64'h777777);
        dac_finished = 1'b1;
        dac_in = 24'h000111;
        step();
        chk("a_next_fin", 64'(req_finished), 64'h1);
        dac_finished = 1'b0;
        req_arm = 3'b000;
        step();
        chk("a_next_clr", 64'(req_finished), 64'h0);

        // Reset mid-XFER (rr_ptr=1, grant goes to 2)
        req_arm = 3'b100;
        step();
        chk("r_gid", 64'(grant_id), 64'h2);
        repeat (4) step();
        #1 rst = 1'b1;
        #1;
        chk("r_arm0", 64'(dac_arm), 64'h0);
        chk("r_busy0", 64'(busy), 64'h0);
        chk("r_fin0", 64'(req_finished), 64'h0);
        chk("r_rin2_0", 64'(rin(2)), 64'h0);
        step();
        rst = 1'b0;
        req_arm = 3'b111;
        step();
        chk("r_regrant", 64'(grant_id), 64'h0);
        chk("r_regrant_arm", 64'(dac_arm), 64'h1);
        dac_finished = 1'b1;
        step();
        chk("r_fin", 64'(req_finished), 64'h1);
        dac_finished = 1'b0;
        req_arm = 3'b000;
        step();

        // Slow DAC release (rr_ptr=1)
        req_arm = 3'b010;
        step();
        chk("l_gid", 64'(grant_id), 64'h1);
        dac_finished = 1'b1;
        dac_in = 24'h0C0C0C;
        step();
        chk("l_fin", 64'(req_finished), 64'h2);
        req_arm = 3'b001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("l_hold_busy", 64'(busy), 64'h1);
            chk("l_hold_arm", 64'(dac_arm), 64'h0);
        end
        dac_finished = 1'b0;
        step();
        chk("l_idle", 64'(busy), 64'h0);
        chk("l_fin_clr", 64'(req_finished), 64'h0);
        step();
        chk("l_next_arm", 64'(dac_arm), 64'h1);
        chk("l_next_gid", 64'(grant_id), 64'h0);
        dac_finished = 1'b1;
        step();
        dac_finished = 1'b0;
        req_arm = 3'b000;
        step();
        chk("l_end", 64'(busy), 64'h0);

`ifdef DAC_SHARE_ARBITER_TIMEOUT_EN
        // Watchdog: DAC never finishes
        timeout_cycles = 16'd8;
        req_arm = 3'b100;
        step();
        chk("t_arm", 64'(dac_arm), 64'h1);
        repeat (7) step();
        chk("t_arm_last", 64'(dac_arm), 64'h1);
        chk("t_err0", 64'(timeout_err), 64'h0);
        step();
        chk("t_arm_lo", 64'(dac_arm), 64'h0);
        chk("t_err", 64'(timeout_err), 64'h1);
        chk("t_fin", 64'(req_finished), 64'h4);
        chk("t_rin2", 64'(rin(2)), 64'h0);
        req_arm = 3'b000;
        step();
        chk("t_idle", 64'(busy), 64'h0);
        chk("t_sticky", 64'(timeout_err), 64'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
